// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with occupancy, status flags and standard/FWFT read modes
module sync_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic        ovf_q, ovf_d, udf_q, udf_d;
    logic        wr_acc, rd_acc;

    assign full         = count_q == DEPTH_C;
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= AF_C;
    assign almost_empty = count_q <= AE_C;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // next-state: acceptance is judged on pre-edge occupancy, flush overrides everything
    always_comb begin
        wr_acc  = wr_en && !full;
        rd_acc  = rd_en && !empty;
        wptr_d  = wptr_q + {{AW{1'b0}}, wr_acc};
        rptr_d  = rptr_q + {{AW{1'b0}}, rd_acc};
        count_d = count_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
        ovf_d   = wr_en && full;
        udf_d   = rd_en && empty;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end
    end

    // pointer, occupancy and error-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // storage array, deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) mem[wptr_q[AW-1:0]] <= wr_data;
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data  = mem[rptr_q[AW-1:0]];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;
            // registered read port: data lands one cycle after an accepted read, held otherwise
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (clr) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rptr_q[AW-1:0]];
                end
            end
            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate
endmodule
